// File: rtl/regfile_mp.sv
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised register file for the decode stage.
//            Provides NUM_RD combinational read ports and one write port.
//            A sequential clear engine zeroes the array one entry per cycle,
//            so the storage flops need no per-entry reset.
// Options  : REGFILE_BYPASS_EN - when defined, a read of the address being
//            written in the same cycle returns the new write data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(DEPTH)-1:0]      wr_addr,
    input  logic [DW-1:0]                 wr_data,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0]          rd_data,
    input  logic                          clr_req,
    output logic                          busy
);

    localparam int AW = $clog2(DEPTH);

    // Controller states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [AW-1:0] clr_idx_q;
    logic [AW-1:0] clr_idx_d;

    // Storage array: no reset, contents are zeroed by the clear engine
    logic [DW-1:0] mem_q [DEPTH];

    logic          w_busy;
    logic          w_wr_ok;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [DW-1:0] w_mem_wdata;

    assign w_busy = (state_q == ST_CLEAR);
    assign busy   = w_busy;

    // A user write is accepted only in IDLE and never to the hardwired zero entry
    always_comb begin
        w_wr_ok = 1'b0;
        if (!w_busy) begin
            w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        end
    end

    // Next-state logic of the clear engine
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                // clr_req is ignored here: a running clear is never restarted
                if (clr_idx_q == c_last_idx) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    // Controller registers; reset restarts a full clear from entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Single array write port shared by the clear engine and the user write.
    // While busy the user inputs are not looked at, so X on them cannot leak in.
    // rst_n gates the clear write so the array is untouched while held in reset.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        if (w_busy) begin
            w_mem_we    = rst_n;
            w_mem_waddr = clr_idx_q;
            w_mem_wdata = '0;
        end else if (w_wr_ok) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = wr_addr;
            w_mem_wdata = wr_data;
        end
    end

    // Array update on the rising edge
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Independent combinational read ports
    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic [DW-1:0] w_rd;

            assign w_ra = rd_addr[p*AW +: AW];

            // Read mux: busy and the zero entry force 0, optional write bypass
            always_comb begin
                w_rd = mem_q[w_ra];
                if (w_busy) begin
                    w_rd = '0;
                end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (w_wr_ok && (w_ra == wr_addr)) begin
                    w_rd = wr_data;
`endif
                end
            end

            assign rd_data[p*DW +: DW] = w_rd;
        end
    endgenerate

endmodule

`default_nettype wire
